// File: rtl/fetch_unit_pkg.sv
// Shared constants for the instruction fetch unit: redirect source encodings and instruction width.
package fetch_unit_pkg;

  localparam int INST_W = 32;

  typedef enum logic [1:0] {
    SRC_NONE   = 2'd0,
    SRC_REG    = 2'd1,
    SRC_JUMP   = 2'd2,
    SRC_BRANCH = 2'd3
  } redir_src_e;

endpackage

// File: rtl/fetch_fifo.sv
// Circular prefetch buffer with wrap-bit pointers; flush empties it in one cycle.
// Push is accepted when not full or when a pop happens in the same cycle.
module fetch_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     push,
  input  logic [W-1:0]             push_data,
  input  logic                     pop,
  output logic [W-1:0]             head_data,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic [W-1:0] mem [DEPTH];
  logic         full;
  logic         do_push;
  logic         do_pop;

  assign count     = wr_ptr - rd_ptr;
  assign empty     = (count == '0);
  assign full      = (count == (AW+1)'(DEPTH));
  assign do_pop    = pop && !empty;
  assign do_push   = push && (!full || do_pop);
  assign head_data = mem[rd_ptr[AW-1:0]];

  // Storage is reset so head outputs are defined (zero) right after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr[AW-1:0]] <= push_data;
        wr_ptr              <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: single-outstanding imem requests feeding a prefetch buffer, with redirects.
// Request-to-inst_valid latency is 2 cycles; fetching stalls while buffer plus in-flight fills DEPTH.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int               WIDTH    = 32,
  parameter int               DEPTH    = 4,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_req,
  output logic [WIDTH-1:0]  imem_addr,
  input  logic [INST_W-1:0] imem_rdata,
  input  logic              redir_valid,
  input  logic [1:0]        redir_src,
  input  logic [WIDTH-1:0]  redir_base,
  input  logic [WIDTH-1:0]  redir_reg,
  input  logic [25:0]       redir_imm,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [INST_W-1:0] inst_data,
  output logic [WIDTH-1:0]  inst_pc,
  output logic [WIDTH-1:0]  inst_pc4,
  output logic              misalign
);

  localparam int AW      = $clog2(DEPTH);
  localparam int ENTRY_W = INST_W + 2 * WIDTH;

  logic [WIDTH-1:0]   fpc;
  logic [WIDTH-1:0]   req_pc;
  logic               inflight;
  logic               req_epoch;
  logic               epoch;
  redir_src_e         src;
  logic               redir_acc;
  logic [WIDTH-1:0]   raw_target;
  logic [WIDTH-1:0]   br_off;
  logic [AW+1:0]      occ_total;
  logic               rsp_ok;
  logic               push;
  logic               pop;
  logic [ENTRY_W-1:0] push_entry;
  logic [ENTRY_W-1:0] head_entry;
  logic               empty;
  logic [AW:0]        count;

  assign src       = redir_src_e'(redir_src);
  assign redir_acc = redir_valid && (src != SRC_NONE);
  assign br_off    = {{(WIDTH-18){redir_imm[15]}}, redir_imm[15:0], 2'b00};

  always_comb begin
    raw_target = fpc;
    unique case (src)
      SRC_REG:    raw_target = redir_reg;
      SRC_JUMP:   raw_target = {redir_base[WIDTH-1:28], redir_imm[25:0], 2'b00};
      SRC_BRANCH: raw_target = redir_base + br_off;
      default:    raw_target = fpc;
    endcase
  end

  // The in-flight word is counted as occupied so the buffer can never overrun.
  assign occ_total = {1'b0, count} + (AW+2)'(inflight);
  assign imem_req  = rst_n && !redir_acc && (occ_total < (AW+2)'(DEPTH));
  assign imem_addr = fpc;

  assign rsp_ok     = inflight && (req_epoch == epoch);
  assign push       = rsp_ok && !redir_acc;
  assign pop        = inst_valid && inst_ready && !redir_acc;
  assign push_entry = {req_pc + WIDTH'(4), req_pc, imem_rdata};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fpc       <= RESET_PC;
      req_pc    <= '0;
      inflight  <= 1'b0;
      req_epoch <= 1'b0;
      epoch     <= 1'b0;
      misalign  <= 1'b0;
    end else begin
      misalign <= redir_acc && (raw_target[1:0] != 2'b00);
      inflight <= imem_req;
      if (redir_acc) begin
        fpc   <= {raw_target[WIDTH-1:2], 2'b00};
        epoch <= ~epoch;
      end else if (imem_req) begin
        fpc       <= fpc + WIDTH'(4);
        req_pc    <= fpc;
        req_epoch <= epoch;
      end
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH),
    .W     (ENTRY_W)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (redir_acc),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .head_data (head_entry),
    .empty     (empty),
    .count     (count)
  );

  assign inst_valid                      = !empty;
  assign {inst_pc4, inst_pc, inst_data} = head_entry;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: streaming, stall, redirects, PC wrap and mid-fetch reset.
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata = 32'h0;
  logic        redir_valid = 1'b0;
  logic [1:0]  redir_src = 2'd0;
  logic [31:0] redir_base = 32'h0;
  logic [31:0] redir_reg = 32'h0;
  logic [25:0] redir_imm = 26'h0;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic [31:0] inst_pc4;
  logic        misalign;

  int n_assert = 0;
  int n_fail   = 0;

  fetch_unit dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .redir_valid (redir_valid),
    .redir_src   (redir_src),
    .redir_base  (redir_base),
    .redir_reg   (redir_reg),
    .redir_imm   (redir_imm),
    .inst_valid  (inst_valid),
    .inst_ready  (inst_ready),
    .inst_data   (inst_data),
    .inst_pc     (inst_pc),
    .inst_pc4    (inst_pc4),
    .misalign    (misalign)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  // Instruction memory: one-cycle read latency.
  always @(posedge clk) begin
    if (imem_req) imem_rdata <= word(imem_addr);
    else          imem_rdata <= 32'hDEAD_BEEF;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic head(input string tag, input logic [31:0] pc);
    logic [31:0] pc4;
    pc4 = pc + 32'd4;
    chk({tag, "_valid"}, {31'b0, inst_valid}, 32'd1);
    chk({tag, "_pc"},    inst_pc,   pc);
    chk({tag, "_data"},  inst_data, word(pc));
    chk({tag, "_pc4"},   inst_pc4,  pc4);
  endtask

  task automatic redir(input logic [1:0] s, input logic [31:0] b, input logic [31:0] r,
                       input logic [25:0] imm);
    redir_valid = 1'b1;
    redir_src   = s;
    redir_base  = b;
    redir_reg   = r;
    redir_imm   = imm;
  endtask

  task automatic redir_clr;
    redir_valid = 1'b0;
    redir_src   = 2'd0;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_req"},      {31'b0, imem_req},   32'd0);
    chk({tag, "_valid"},    {31'b0, inst_valid}, 32'd0);
    chk({tag, "_misalign"}, {31'b0, misalign},   32'd0);
    chk({tag, "_addr"},     imem_addr,           32'h0);
    chk({tag, "_data"},     inst_data,           32'h0);
    chk({tag, "_pc"},       inst_pc,             32'h0);
    chk({tag, "_pc4"},      inst_pc4,            32'h0);
  endtask

  initial begin
    step;
    step;
    chk_reset("rst0");

    // Release with consumer stalled: buffer fills to 4, fetch stops.
    rst_n = 1'b1;
    #1;
    for (int k = 0; k < 10; k++) begin
      chk($sformatf("stall_req%0d", k),   {31'b0, imem_req},   (k < 4) ? 32'd1 : 32'd0);
      chk($sformatf("stall_addr%0d", k),  imem_addr,           (k < 4) ? 32'(4 * k) : 32'h10);
      chk($sformatf("stall_valid%0d", k), {31'b0, inst_valid}, (k >= 2) ? 32'd1 : 32'd0);
      if (k >= 2) chk($sformatf("stall_pc%0d", k), inst_pc, 32'h0);
      step;
    end

    // Drain in order.
    inst_ready = 1'b1;
    #1;
    chk("drain_req_full", {31'b0, imem_req}, 32'd0);
    head("drain0", 32'h0);
    step;
    head("drain1", 32'h4);
    chk("drain_addr1", imem_addr, 32'h10);
    step;
    head("drain2", 32'h8);
    chk("drain_addr2", imem_addr, 32'h14);
    step;
    head("drain3", 32'hC);
    chk("drain_addr3", imem_addr, 32'h18);

    // redir_src 0 is ignored.
    step;
    redir(2'd0, 32'h0, 32'h0, 26'h0);
    #1;
    chk("none_req", {31'b0, imem_req}, 32'd1);
    chk("none_addr", imem_addr, 32'h1C);
    head("none_head", 32'h10);

    // Branch: 0x100 + (-2 << 2) = 0xF8.
    step;
    head("pre_branch", 32'h14);
    redir(2'd3, 32'h100, 32'h0, 26'h000FFFE);
    #1;
    chk("br_req_blocked", {31'b0, imem_req}, 32'd0);
    step;
    redir_clr();
    #1;
    chk("br_req", {31'b0, imem_req}, 32'd1);
    chk("br_addr", imem_addr, 32'hF8);
    chk("br_flush", {31'b0, inst_valid}, 32'd0);
    chk("br_misalign", {31'b0, misalign}, 32'd0);
    step;
    chk("br_stale_drop", {31'b0, inst_valid}, 32'd0);
    chk("br_addr2", imem_addr, 32'hFC);
    step;
    head("br_head", 32'hF8);

    // Jump keeps base[31:28].
    step;
    redir(2'd2, 32'hA000_0004, 32'h0, 26'h0000010);
    #1;
    chk("jmp_req_blocked", {31'b0, imem_req}, 32'd0);
    step;
    redir_clr();
    #1;
    chk("jmp_addr", imem_addr, 32'hA000_0040);
    chk("jmp_flush", {31'b0, inst_valid}, 32'd0);
    step;
    step;
    head("jmp_head", 32'hA000_0040);

    // Register-indirect with low bits set.
    step;
    redir(2'd1, 32'h0, 32'h203, 26'h0);
    step;
    redir_clr();
    #1;
    chk("reg_addr", imem_addr, 32'h200);
    chk("reg_misalign", {31'b0, misalign}, 32'd1);
    step;
    chk("reg_misalign_end", {31'b0, misalign}, 32'd0);
    step;
    head("reg_head", 32'h200);

    // PC wrap at top of address space.
    step;
    redir(2'd1, 32'h0, 32'hFFFF_FFFC, 26'h0);
    step;
    redir_clr();
    #1;
    chk("wrap_addr0", imem_addr, 32'hFFFF_FFFC);
    chk("wrap_misalign", {31'b0, misalign}, 32'd0);
    step;
    chk("wrap_addr1", imem_addr, 32'h0);
    step;
    head("wrap_head0", 32'hFFFF_FFFC);
    chk("wrap_pc4", inst_pc4, 32'h0);
    step;
    head("wrap_head1", 32'h0);

    // Fill 3 entries with one in flight, then reset mid-fetch.
    step;
    inst_ready = 1'b0;
    redir(2'd1, 32'h0, 32'h300, 26'h0);
    step;
    redir_clr();
    step;
    step;
    step;
    step;
    chk("pre_rst_req", {31'b0, imem_req}, 32'd0);
    chk("pre_rst_addr", imem_addr, 32'h310);
    chk("pre_rst_valid", {31'b0, inst_valid}, 32'd1);
    chk("pre_rst_pc", inst_pc, 32'h300);
    rst_n = 1'b0;
    #1;
    chk_reset("rst1");
    step;
    step;
    chk_reset("rst1_hold");

    // Restart at RESET_PC with consumer ready.
    rst_n      = 1'b1;
    inst_ready = 1'b1;
    #1;
    chk("run_req0", {31'b0, imem_req}, 32'd1);
    chk("run_addr0", imem_addr, 32'h0);
    chk("run_valid0", {31'b0, inst_valid}, 32'd0);
    step;
    chk("run_addr1", imem_addr, 32'h4);
    chk("run_valid1", {31'b0, inst_valid}, 32'd0);
    step;
    head("run_head0", 32'h0);
    chk("run_addr2", imem_addr, 32'h8);
    step;
    head("run_head1", 32'h4);
    step;
    head("run_head2", 32'h8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
